// File: rtl/kgp_alu.sv
// KGP-RISC execute-stage ALU: add, negate, and/xor, constant/variable shifts.
// The combinational result is registered, so outputs follow operands by one clock.
module kgp_alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] input1,
   input  logic [31:0] input2,
   input  logic [4:0]  shamt,
   input  logic [3:0]  control,
   output logic [31:0] out,
   output logic        flag
);

   // No handshake: every rising edge out of reset captures a new result; there is no valid/ready pair.
   logic [4:0]         sa;
   logic [32:0]        sum;
   logic [32:0]        neg;
   logic signed [31:0] sra;
   logic [31:0]        res;
   logic               res_flag;

   always_comb begin
      sa  = control[3] ? input2[4:0] : shamt;
      sum = {1'b0, input1} + {1'b0, input2};
      // The carry out of ~b + 1 is set only for b = 0.
      neg = {1'b0, ~input2} + 33'd1;
      sra = $signed(input1) >>> sa;

      res      = 32'd0;
      res_flag = 1'b0;
      case (control)
         4'b0000: {res_flag, res} = sum;
         4'b0001: {res_flag, res} = neg;
         4'b0010: res = input1 & input2;
         4'b0011: res = input1 ^ input2;
         4'b0100,
         4'b1100: res = input1 << sa;
         4'b0101,
         4'b1101: res = input1 >> sa;
         4'b0110,
         4'b1110: res = sra;
         default: begin
            res      = 32'd0;
            res_flag = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out  <= 32'd0;
         flag <= 1'b0;
      end else begin
         out  <= res;
         flag <= res_flag;
      end
   end

endmodule

// File: tb/tb_kgp_alu.sv
// Directed-vector bench for kgp_alu: reset, every operation, shift boundaries, back-to-back latency.
module tb_kgp_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] input1;
   logic [31:0] input2;
   logic [4:0]  shamt;
   logic [3:0]  control;
   logic [31:0] out;
   logic        flag;

   int n_checks;
   int n_errors;
   logic [32:0] prev_exp;

   kgp_alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .input1  (input1),
      .input2  (input2),
      .shamt   (shamt),
      .control (control),
      .out     (out),
      .flag    (flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got flag=%0b out=%h, expected flag=%0b out=%h",
                  tag, got[32], got[31:0], exp[32], exp[31:0]);
      end
   endtask

   // Drive one operation on the falling edge; the outputs must still hold the
   // previous result until the next rising edge, then show the new one.
   task automatic run(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh,
                      input logic [31:0] exp_out, input logic exp_flag);
      @(negedge clk);
      control = ctl;
      input1  = a;
      input2  = b;
      shamt   = sh;
      #1;
      check({tag, "_hold"}, {flag, out}, prev_exp);
      @(posedge clk);
      #1;
      check(tag, {flag, out}, {exp_flag, exp_out});
      prev_exp = {exp_flag, exp_out};
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      input1   = 32'd0;
      input2   = 32'd0;
      shamt    = 5'd0;
      control  = 4'b0000;
      prev_exp = 33'd0;

      // Operands that would give a nonzero result must not leak through reset.
      input1 = 32'd7;
      input2 = 32'd9;
      repeat (2) @(posedge clk);
      #1;
      check("reset", {flag, out}, 33'd0);
      @(negedge clk);
      rst_n = 1'b1;
      input1 = 32'd0;
      input2 = 32'd0;

      run("add_small",  4'b0000, 32'd105, 32'd106, 5'd0, 32'd211, 1'b0);
      run("add_ovf",    4'b0000, 32'h7FFF_FFFF, 32'd106, 5'd0, -32'sd2147483543, 1'b0);
      run("add_carry",  4'b0000, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'd0, 1'b1);
      run("comp_pos",   4'b0001, 32'd55, 32'd896989867, 5'd0, -32'sd896989867, 1'b0);
      run("comp_neg",   4'b0001, 32'd0, -32'sd896989867, 5'd0, 32'd896989867, 1'b0);
      run("comp_zero",  4'b0001, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'd0, 1'b1);
      run("and",        4'b0010, 32'd111, 32'd106, 5'd0, 32'd106, 1'b0);
      run("xor",        4'b0011, 32'd259, 32'd106, 5'd0, 32'd361, 1'b0);
      run("shll",       4'b0100, 32'd259, 32'd31, 5'd4, 32'd4144, 1'b0);
      run("shll_zero",  4'b0100, 32'd259, 32'd7, 5'd0, 32'd259, 1'b0);
      run("shllv_8",    4'b1100, -32'sd259, 32'd8, 5'd3, -32'sd66304, 1'b0);
      run("shllv_31",   4'b1100, -32'sd259, 32'd31, 5'd0, 32'h8000_0000, 1'b0);
      run("shrl",       4'b0101, 32'd119, 32'd2, 5'd4, 32'd7, 1'b0);
      run("shrlv",      4'b1101, -32'sd119, 32'd3, 5'd9, 32'd536870897, 1'b0);
      run("shra",       4'b0110, -32'sd119, 32'd1, 5'd4, -32'sd8, 1'b0);
      run("shrav_3",    4'b1110, -32'sd119, 32'd3, 5'd0, -32'sd15, 1'b0);
      run("shrav_106",  4'b1110, -32'sd119, 32'd106, 5'd1, 32'hFFFF_FFFF, 1'b0);
      run("shrav_pos",  4'b1110, 32'd119, 32'd106, 5'd0, 32'd0, 1'b0);
      run("undef_1111", 4'b1111, 32'd105, 32'd106, 5'd4, 32'd0, 1'b0);
      run("add_after",  4'b0000, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1, 1'b1);
      run("undef_0111", 4'b0111, 32'd5, 32'd6, 5'd1, 32'd0, 1'b0);
      run("undef_1000", 4'b1000, 32'd5, 32'd6, 5'd1, 32'd0, 1'b0);
      run("shrl_31",    4'b0101, 32'h8000_0000, 32'd0, 5'd31, 32'd1, 1'b0);

      // Reset asserted between edges must clear the outputs without a clock.
      run("pre_reset",  4'b0000, 32'd40, 32'd2, 5'd0, 32'd42, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", {flag, out}, 33'd0);
      @(negedge clk);
      control = 4'b0000;
      input1  = 32'd5;
      input2  = 32'd6;
      rst_n   = 1'b1;
      #1;
      check("reset_held", {flag, out}, 33'd0);
      @(posedge clk);
      #1;
      check("post_reset", {flag, out}, {1'b0, 32'd11});
      prev_exp = {1'b0, 32'd11};
      run("post_reset2", 4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'hF0F0_0F0F, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no end of stimulus, expected finish before 100000");
      $fatal(1);
   end

endmodule
